// File: rtl/flit_transmitter_if.sv
// Handshake bundle between the upstream FIFO/switch control and the flit transmitter.
// master = transmitter side, slave = FIFO/switch/downstream side.
interface flit_transmitter_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  logic [WIDTH-1:0]         head;
  logic [$clog2(DEPTH):0]   counter;
  logic                     pull;
  logic                     h;
  logic                     ack_h;
  logic                     data_av;
  logic [WIDTH-1:0]         data_out;
  logic                     credit_i;
  logic                     sender;

  modport master (
    input  head, counter, ack_h, credit_i,
    output pull, h, data_av, data_out, sender
  );

  modport slave (
    output head, counter, ack_h, credit_i,
    input  pull, h, data_av, data_out, sender
  );
endinterface

// File: rtl/flit_transmitter.sv
// Sends header/size/payload packets from the upstream FIFO after a routing grant.
// Optional feature: define PKT_STATS_EN to add the 16-bit pkt_sent completed-packet counter.
module flit_transmitter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  flit_transmitter_if.master tx
`ifdef PKT_STATS_EN
  ,
  output logic [15:0]        pkt_sent
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] flits_left;
  logic             h_q;
  logic             sender_q;

  logic [CNT_W-1:0] occupancy;
  logic             fifo_has_data;
  logic             in_data;
  logic             data_av;
  logic             transfer;
  logic             final_transfer;

  assign occupancy = tx.counter;

  // Transfer qualification is combinational so pull pops the FIFO on the same edge.
  always_comb begin
    fifo_has_data  = (occupancy != '0);
    in_data        = (state == S_HEADER) || (state == S_SIZE) || (state == S_PAYLOAD);
    data_av        = in_data && fifo_has_data && !reset;
    transfer       = data_av && tx.credit_i;
    final_transfer = transfer &&
                     (((state == S_SIZE) && (tx.head == '0)) ||
                      ((state == S_PAYLOAD) && (flits_left == WIDTH'(1))));
  end

  assign tx.data_av  = data_av;
  assign tx.pull     = transfer;
  assign tx.data_out = tx.head;
  assign tx.h        = h_q;
  assign tx.sender   = sender_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      flits_left <= '0;
      h_q        <= 1'b0;
      sender_q   <= 1'b0;
`ifdef PKT_STATS_EN
      pkt_sent   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_has_data) begin
            state <= S_REQ;
            h_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (tx.ack_h) begin
            state    <= S_HEADER;
            h_q      <= 1'b0;
            sender_q <= 1'b1;
          end
        end
        S_HEADER: begin
          if (transfer) state <= S_SIZE;
        end
        // A zero size flit ends the packet right after the size transfer.
        S_SIZE: begin
          if (transfer) begin
            flits_left <= tx.head;
            if (tx.head == '0) begin
              state    <= S_IDLE;
              sender_q <= 1'b0;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (transfer) begin
            flits_left <= flits_left - WIDTH'(1);
            if (flits_left == WIDTH'(1)) begin
              state    <= S_IDLE;
              sender_q <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef PKT_STATS_EN
      if (final_transfer) pkt_sent <= pkt_sent + 16'd1;
`endif
    end
  end

`ifndef PKT_STATS_EN
  logic unused_final;
  assign unused_final = final_transfer;
`endif

endmodule

// File: tb/tb_flit_transmitter.sv
// Directed scoreboard bench for flit_transmitter: bench-side FIFO model feeds head/counter,
// expected flits are queued on load and compared whenever the DUT pulls.
module tb_flit_transmitter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  flit_transmitter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef PKT_STATS_EN
  logic [15:0] pkt_sent;
`endif

  flit_transmitter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .tx    (bus)
`ifdef PKT_STATS_EN
    ,
    .pkt_sent (pkt_sent)
`endif
  );

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  logic obs_pull, obs_h, obs_sender, obs_av;
  logic [WIDTH-1:0] obs_data;
  logic [WIDTH-1:0] exp_flit;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Push a whole packet into the FIFO model and the expected-output queue.
  task automatic load_packet(input logic [WIDTH-1:0] hdr, input logic [WIDTH-1:0] size,
                             input logic [WIDTH-1:0] base);
    fifo_q.push_back(hdr);
    exp_q.push_back(hdr);
    fifo_q.push_back(size);
    exp_q.push_back(size);
    for (int i = 0; i < int'(size); i++) begin
      fifo_q.push_back(base + WIDTH'(i));
      exp_q.push_back(base + WIDTH'(i));
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, pop the FIFO model at posedge.
  task automatic apply_stimulus(input logic ack, input logic credit, input logic rst);
    @(negedge clock);
    reset        = rst;
    bus.ack_h    = ack;
    bus.credit_i = credit;
    bus.counter  = CNT_W'(fifo_q.size());
    bus.head     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    obs_pull   = bus.pull;
    obs_h      = bus.h;
    obs_sender = bus.sender;
    obs_av     = bus.data_av;
    obs_data   = bus.data_out;
    if (obs_pull === 1'b1) begin
      check_output("sb_flit_available", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_flit = exp_q.pop_front();
        check_output("sb_data_out", 32'(obs_data), 32'(exp_flit));
      end
    end
    @(posedge clock);
    if ((obs_pull === 1'b1) && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
  endtask

  initial begin
    reset        = 1'b1;
    bus.ack_h    = 1'b0;
    bus.credit_i = 1'b0;
    bus.head     = '0;
    bus.counter  = '0;

    // Reset state
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("rst_h", 32'(obs_h), 32'd0);
    check_output("rst_sender", 32'(obs_sender), 32'd0);
    check_output("rst_pull", 32'(obs_pull), 32'd0);
    check_output("rst_data_av", 32'(obs_av), 32'd0);
`ifdef PKT_STATS_EN
    check_output("rst_pkt_sent", 32'(pkt_sent), 32'd0);
`endif

    // Basic packet, immediate grant, full credit
    load_packet(16'h0011, 16'h0003, 16'h00A1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s1_c0_h", 32'(obs_h), 32'd0);
    check_output("s1_c0_pull", 32'(obs_pull), 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s1_c1_h", 32'(obs_h), 32'd1);
    check_output("s1_c1_pull", 32'(obs_pull), 32'd0);
    check_output("s1_c1_sender", 32'(obs_sender), 32'd0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output("s1_xfer_pull", 32'(obs_pull), 32'd1);
      check_output("s1_xfer_sender", 32'(obs_sender), 32'd1);
      check_output("s1_xfer_h", 32'(obs_h), 32'd0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s1_end_sender", 32'(obs_sender), 32'd0);
    check_output("s1_end_pull", 32'(obs_pull), 32'd0);
    check_output("s1_end_av", 32'(obs_av), 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s1_idle_h", 32'(obs_h), 32'd0);
    check_output("s1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Grant delayed by 4 cycles
    load_packet(16'h0011, 16'h0003, 16'h00A1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("s2_wait_h", 32'(obs_h), 32'd1);
      check_output("s2_wait_pull", 32'(obs_pull), 32'd0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s2_grant_h", 32'(obs_h), 32'd1);
    check_output("s2_grant_pull", 32'(obs_pull), 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s2_hdr_h", 32'(obs_h), 32'd0);
    check_output("s2_hdr_pull", 32'(obs_pull), 32'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s2_end_sender", 32'(obs_sender), 32'd0);
    check_output("s2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Credit toggling during payload
    load_packet(16'h0011, 16'h0003, 16'h00B1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s3_h", 32'(obs_h), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s3_hdr_pull", 32'(obs_pull), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s3_size_pull", 32'(obs_pull), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s3_p1_pull", 32'(obs_pull), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("s3_gap1_pull", 32'(obs_pull), 32'd0);
    check_output("s3_gap1_av", 32'(obs_av), 32'd1);
    check_output("s3_gap1_sender", 32'(obs_sender), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s3_p2_pull", 32'(obs_pull), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("s3_gap2_pull", 32'(obs_pull), 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s3_p3_pull", 32'(obs_pull), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s3_idle_credit_pull", 32'(obs_pull), 32'd0);
    check_output("s3_end_sender", 32'(obs_sender), 32'd0);
    check_output("s3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero-size packet
    load_packet(16'h0011, 16'h0000, 16'h0000);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s4_hdr_pull", 32'(obs_pull), 32'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s4_size_pull", 32'(obs_pull), 32'd1);
    check_output("s4_size_sender", 32'(obs_sender), 32'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s4_end_sender", 32'(obs_sender), 32'd0);
    check_output("s4_end_h", 32'(obs_h), 32'd0);
    check_output("s4_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef PKT_STATS_EN
    check_output("s4_pkt_sent", 32'(pkt_sent), 32'd4);
`endif

    // Reset mid-packet after the second payload flit
    load_packet(16'h0011, 16'h0005, 16'h00C1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output("s5_xfer_pull", 32'(obs_pull), 32'd1);
    end
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("s5_rst_pull", 32'(obs_pull), 32'd0);
    check_output("s5_rst_av", 32'(obs_av), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s5_after_h", 32'(obs_h), 32'd0);
    check_output("s5_after_sender", 32'(obs_sender), 32'd0);
    check_output("s5_after_pull", 32'(obs_pull), 32'd0);
    check_output("s5_after_av", 32'(obs_av), 32'd0);
`ifdef PKT_STATS_EN
    check_output("s5_pkt_sent", 32'(pkt_sent), 32'd0);
`endif
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s5_idle_h", 32'(obs_h), 32'd0);

    // Two packets back-to-back
    load_packet(16'h0011, 16'h0001, 16'h00D1);
    load_packet(16'h0022, 16'h0002, 16'h00E1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s6_a_h", 32'(obs_h), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output("s6_a_pull", 32'(obs_pull), 32'd1);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s6_dead_h", 32'(obs_h), 32'd0);
    check_output("s6_dead_sender", 32'(obs_sender), 32'd0);
    check_output("s6_dead_pull", 32'(obs_pull), 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s6_b_h", 32'(obs_h), 32'd1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output("s6_b_pull", 32'(obs_pull), 32'd1);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s6_end_sender", 32'(obs_sender), 32'd0);
    check_output("s6_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef PKT_STATS_EN
    check_output("s6_pkt_sent", 32'(pkt_sent), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
